// File: rtl/data_sram_pkg.sv
// Shared encodings and response-queue entry layout for the data SRAM slave.
package data_sram_pkg;

  // Access size encodings carried on data_sram_size (byte lanes come from wstrb).
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Largest supported request-to-response latency.
  localparam int LATENCY_MAX = 7;

  // Response-queue entry field widths.
  localparam int DATA_W  = 32;
  localparam int TIMER_W = $clog2(LATENCY_MAX + 1);
  localparam int ENTRY_W = 1 + DATA_W + TIMER_W;

  // One outstanding response: kind, read snapshot, cycles left before it may issue.
  typedef struct packed {
    logic               wr;
    logic [DATA_W-1:0]  rdata;
    logic [TIMER_W-1:0] timer;
  } resp_entry_t;

endpackage

// File: rtl/sram_resp_fifo.sv
// In-order response queue. Each entry carries a countdown timer; the head
// issues as soon as its timer has reached zero, and pops in that same cycle.
module sram_resp_fifo
  import data_sram_pkg::*;
#(
  parameter int QDEPTH  = 2,
  parameter int LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    push,
  input  logic                    push_wr,
  input  logic [DATA_W-1:0]       push_rdata,
  output logic                    resp_valid,
  output logic                    resp_wr,
  output logic [DATA_W-1:0]       resp_rdata,
  output logic [$clog2(QDEPTH):0] count
);

  localparam int PW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int LAT_C = (LATENCY < 1) ? 1 : ((LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(LAT_C - 1);

  resp_entry_t   q [QDEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          pop;

  // Pointers wrap modulo QDEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Head issues once its timer is zero; there is no back-pressure, so it always pops.
  always_comb begin
    pop        = (count != '0) && (q[rd_ptr].timer == '0);
    resp_valid = pop;
    resp_wr    = q[rd_ptr].wr;
    resp_rdata = q[rd_ptr].rdata;
  end

  // Queue state: timers count down, push fills the tail, pop advances the head.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < QDEPTH; i++) q[i] <= '0;
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (q[i].timer != '0) q[i].timer <= q[i].timer - 1'b1;
      end
      // A push never lands on the head being popped: push needs a free slot
      // and the popped slot only becomes free after this edge.
      if (push) begin
        q[wr_ptr] <= '{wr: push_wr, rdata: push_rdata, timer: TIMER_LOAD};
        wr_ptr    <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/data_sram_resp.sv
// Data SRAM slave with split address/data handshakes: requests are accepted
// on addr_ok, serviced against the local word array at the accept edge, and
// answered in order on data_ok after a fixed minimum latency.
module data_sram_resp
  import data_sram_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 1,
  parameter int QDEPTH     = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int CW = $clog2(QDEPTH) + 1;

  // Handshake: a request transfers on any rising edge where req and addr_ok
  // are both high; addr_ok depends only on queue occupancy, never on req.
  // data_ok is a one-cycle pulse per accepted request, in acceptance order,
  // and the master must take it (there is no response-side ready).

  logic [DATA_W-1:0]     mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  accept;
  logic [DATA_W-1:0]     snap;
  logic                  resp_valid;
  logic                  resp_wr;
  logic [DATA_W-1:0]     resp_rdata;
  logic [CW-1:0]         count;
  logic                  unused_ok;

  // Request decode: word index aliases on the upper address bits.
  always_comb begin
    idx               = data_sram_addr[DEPTH_LOG2+1:2];
    data_sram_addr_ok = resetn & (count < CW'(QDEPTH));
    accept            = data_sram_req & data_sram_addr_ok;
    snap              = data_sram_wr ? '0 : mem[idx];
  end

  // Size, byte offset and upper address bits carry no function here.
  assign unused_ok = &{1'b0, data_sram_size, data_sram_addr[1:0],
                       data_sram_addr[31:DEPTH_LOG2+2]};

  // Storage array (not reset): byte-lane writes at the accept edge.
  always_ff @(posedge clk) begin
    if (accept && data_sram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wstrb[i]) mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  sram_resp_fifo #(
    .QDEPTH  (QDEPTH),
    .LATENCY (LATENCY)
  ) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push       (accept),
    .push_wr    (data_sram_wr),
    .push_rdata (snap),
    .resp_valid (resp_valid),
    .resp_wr    (resp_wr),
    .resp_rdata (resp_rdata),
    .count      (count)
  );

  // Response outputs: read data is driven only during a read's data_ok pulse.
  always_comb begin
    data_sram_data_ok = resp_valid;
    data_sram_rdata   = (resp_valid && !resp_wr) ? resp_rdata : 32'h0;
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: three instances (LATENCY 1, 3, 4; QDEPTH 2),
// directed requests, and a scoreboard that checks every data_ok pulse for
// its read data and its cycle.
module tb_data_sram_resp;

  localparam int ND = 3;
  localparam int W  = 64;  // {expected cycle, expected rdata}
  localparam int LAT [ND] = '{1, 3, 4};

  logic clk = 1'b0;
  int   cyc = 0;

  logic        rstn   [ND];
  logic        req    [ND];
  logic        wr     [ND];
  logic [1:0]  size   [ND];
  logic [3:0]  wstrb  [ND];
  logic [31:0] addr   [ND];
  logic [31:0] wdata  [ND];
  logic        addr_ok[ND];
  logic        data_ok[ND];
  logic [31:0] rdata  [ND];

  logic [W-1:0] exp_q[ND][$];
  int last_rsp[ND];
  int ok_cnt  [ND];
  int n_cmp  = 0;
  int n_fail = 0;

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    data_sram_resp #(
      .DEPTH_LOG2 (8),
      .LATENCY    (LAT[g]),
      .QDEPTH     (2)
    ) u_dut (
      .clk               (clk),
      .resetn            (rstn[g]),
      .data_sram_req     (req[g]),
      .data_sram_wr      (wr[g]),
      .data_sram_size    (size[g]),
      .data_sram_wstrb   (wstrb[g]),
      .data_sram_addr    (addr[g]),
      .data_sram_wdata   (wdata[g]),
      .data_sram_addr_ok (addr_ok[g]),
      .data_sram_data_ok (data_ok[g]),
      .data_sram_rdata   (rdata[g])
    );
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Driver: present a request until accepted (bounded), push its expected response.
  task automatic issue(input int d, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] st,
                       input logic [31:0] exp_rd, output int n);
    int e;
    req[d] = 1'b1; wr[d] = w; addr[d] = a; wdata[d] = wd; wstrb[d] = st; size[d] = 2'd2;
    n = -1;
    for (int t = 0; t < 40 && n < 0; t++) begin
      @(negedge clk);
      if (addr_ok[d]) begin
        n = cyc;
        e = n + LAT[d];
        if (e <= last_rsp[d]) e = last_rsp[d] + 1;
        last_rsp[d] = e;
        exp_q[d].push_back({e[31:0], exp_rd});
      end
      @(posedge clk); #1;
    end
    req[d] = 1'b0;
    if (n < 0) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout dut%0d: addr %h never accepted", d, a);
    end
  endtask

  // Wait (bounded) until every expected response of one instance has been seen.
  task automatic drain(input int d);
    for (int t = 0; t < 100 && exp_q[d].size() != 0; t++) @(posedge clk);
    #1;
  endtask

  // Monitor: every data_ok pulse pops the scoreboard and is compared.
  task automatic monitor();
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        if (data_ok[d]) begin
          ok_cnt[d]++;
          n_cmp++;
          if (exp_q[d].size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_data_ok dut%0d: cycle %0d rdata %h, none expected", d, cyc, rdata[d]);
          end else begin
            e = exp_q[d].pop_front();
            if (rdata[d] !== e[31:0] || cyc != int'(e[63:32])) begin
              n_fail++;
              $display("FAIL resp dut%0d: got rdata %h cycle %0d expected rdata %h cycle %0d",
                       d, rdata[d], cyc, e[31:0], e[63:32]);
            end
          end
        end
      end
    end
  endtask

  initial begin
    int n, n1, n2;
    int nb[4];
    int ok_before;

    // Reset block.
    for (int d = 0; d < ND; d++) begin
      rstn[d] = 1'b0; req[d] = 1'b0; wr[d] = 1'b0; size[d] = 2'd0;
      wstrb[d] = 4'h0; addr[d] = 32'h0; wdata[d] = 32'h0;
      last_rsp[d] = -1; ok_cnt[d] = 0;
    end
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_addr_ok", {31'h0, addr_ok[0]}, 32'h0);
    check("reset_data_ok", {31'h0, data_ok[0]}, 32'h0);
    check("reset_rdata", rdata[0], 32'h0);
    @(posedge clk); #1;
    for (int d = 0; d < ND; d++) rstn[d] = 1'b1;
    @(negedge clk);
    check("first_cycle_addr_ok", {31'h0, addr_ok[0]}, 32'h1);
    @(posedge clk); #1;

    // LATENCY=1: write then read back-to-back.
    issue(0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 32'h0, n1);
    issue(0, 1'b0, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF, n2);
    check("b2b_accept_gap", n2 - n1, 32'd1);
    // Byte offset bits are ignored.
    issue(0, 1'b0, 32'h103, 32'h0, 4'h0, 32'hDEADBEEF, n);

    // Byte strobes.
    issue(0, 1'b1, 32'h200, 32'h11223344, 4'hF, 32'h0, n);
    issue(0, 1'b1, 32'h200, 32'h0000AA00, 4'b0010, 32'h0, n);
    issue(0, 1'b0, 32'h200, 32'h0, 4'h0, 32'h1122AA44, n);
    issue(0, 1'b1, 32'h200, 32'hAABB0000, 4'b1100, 32'h0, n);
    issue(0, 1'b0, 32'h200, 32'h0, 4'h0, 32'hAABBAA44, n);

    // Address aliasing above DEPTH_LOG2.
    issue(0, 1'b1, 32'h0000_0010, 32'h5A5A5A5A, 4'hF, 32'h0, n);
    issue(0, 1'b0, 32'h0000_0410, 32'h0, 4'h0, 32'h5A5A5A5A, n);

    // wstrb=0 still answers and leaves memory unchanged.
    issue(0, 1'b1, 32'h300, 32'h12345678, 4'hF, 32'h0, n);
    issue(0, 1'b1, 32'h300, 32'hFFFFFFFF, 4'h0, 32'h0, n);
    issue(0, 1'b0, 32'h300, 32'h0, 4'h0, 32'h12345678, n);
    drain(0);

    // LATENCY=3, QDEPTH=2: four reads with req held high.
    for (int i = 0; i < 4; i++)
      issue(1, 1'b1, 32'(4 * i), 32'hA0000000 + 32'(i), 4'hF, 32'h0, n);
    drain(1);
    for (int i = 0; i < 4; i++)
      issue(1, 1'b0, 32'(4 * i), 32'h0, 4'h0, 32'hA0000000 + 32'(i), nb[i]);
    check("full_gap_2nd", nb[1] - nb[0], 32'd1);
    check("full_gap_3rd", nb[2] - nb[0], 32'd4);
    check("full_gap_4th", nb[3] - nb[0], 32'd5);
    drain(1);

    // LATENCY=4: reset with two reads outstanding.
    issue(2, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 32'h0, n);
    drain(2);
    issue(2, 1'b0, 32'h40, 32'h0, 4'h0, 32'hCAFEF00D, n);
    issue(2, 1'b0, 32'h40, 32'h0, 4'h0, 32'hCAFEF00D, n);
    rstn[2] = 1'b0;
    exp_q[2].delete();
    last_rsp[2] = -1;
    ok_before = ok_cnt[2];
    @(negedge clk);
    check("midreset_addr_ok", {31'h0, addr_ok[2]}, 32'h0);
    check("midreset_data_ok", {31'h0, data_ok[2]}, 32'h0);
    @(posedge clk); #1;
    rstn[2] = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("discarded_responses", ok_cnt[2] - ok_before, 32'd0);
    check("post_reset_addr_ok", {31'h0, addr_ok[2]}, 32'h1);
    @(posedge clk); #1;
    issue(2, 1'b0, 32'h40, 32'h0, 4'h0, 32'hCAFEF00D, n);

    // Final report.
    for (int d = 0; d < ND; d++) begin
      drain(d);
      check($sformatf("leftover_dut%0d", d), exp_q[d].size(), 32'd0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/data_sram_resp.md
DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 Parameter DEPTH_LOG2, default 8, word-index width; storage is 2**DEPTH_LOG2 32-bit words.
REQ-002 Parameter LATENCY, default 1, range 1..7, minimum cycles from request acceptance to data_ok.
REQ-003 Parameter QDEPTH, default 2, maximum outstanding accepted requests.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 resetn  input  1  asynchronous assert, active-low reset.
REQ-006 data_sram_req  input  1  master request valid.
REQ-007 data_sram_wr  input  1  1 = write, 0 = read.
REQ-008 data_sram_size  input  2  0 = byte, 1 = half, 2 = word; informational only, wstrb governs writes.
REQ-009 data_sram_wstrb  input  4  byte-lane write enables.
REQ-010 data_sram_addr  input  32  byte address.
REQ-011 data_sram_wdata  input  32  write data.
REQ-012 data_sram_addr_ok  output  1  request accepted this cycle when high together with req.
REQ-013 data_sram_data_ok  output  1  one-cycle response pulse, one per accepted request.
REQ-014 data_sram_rdata  output  32  read data, valid only while data_ok is high for a read.

Function
REQ-015 Accept = req & addr_ok; addr_ok = resetn & (count < QDEPTH); no same-cycle bypass when full.
REQ-016 Word index = addr[DEPTH_LOG2+1:2]; higher bits ignored (aliasing wrap); addr[1:0] ignored.
REQ-017 Accepted write: byte lane i of the indexed word takes wdata lane i at the accept edge iff wstrb[i]; wstrb=0 leaves memory unchanged but still gets a response.
REQ-018 Accepted read: indexed word is snapshotted into the queue entry at the accept edge, reflecting all earlier accepted writes.
REQ-019 Queue is FIFO; entry holds {wr, rdata, timer}; timer loads LATENCY-1 on accept and decrements per cycle to 0, saturating.
REQ-020 data_ok is high in a cycle iff the queue is non-empty and the head timer is 0; the head pops at that edge.
REQ-021 Request accepted in cycle N responds in cycle max(N+LATENCY, previous response cycle+1); at most one data_ok per cycle; responses strictly in order.
REQ-022 rdata = head snapshot when data_ok & ~wr, else 32'h0.
REQ-023 Simultaneous accept and pop: count unchanged; pointers both advance; the accept uses the slot freed by the pop only from the next cycle.
REQ-024 No back-pressure on data_ok: the master is required to consume every pulse.
REQ-025 Pointers are log2(QDEPTH) bits and wrap modulo QDEPTH; count width is log2(QDEPTH)+1.

Reset
REQ-026 While resetn is low: addr_ok=0, data_ok=0, rdata=0, count=0, pointers=0, timers=0.
REQ-027 Reset during outstanding requests discards them; no data_ok follows for them after release.
REQ-028 Memory array is not reset; contents are undefined until written.
REQ-029 Release is synchronised by design; first acceptance is possible in the first cycle with resetn high.

Structure
REQ-030 Package data_sram_pkg holds size encodings (SIZE_B/H/W), LATENCY_MAX=7, and the queue-entry field widths.
REQ-031 One sub-module, sram_resp_fifo (parameterised QDEPTH FIFO with per-entry timers), instantiated once; the storage array stays in data_sram_resp.

Verification
REQ-032 LATENCY=1: write 0x100 wdata 0xDEADBEEF wstrb 4'hF in cycle N, read 0x100 in N+1 -> data_ok in N+1 (write, rdata 0) and N+2 with rdata 0xDEADBEEF.
REQ-033 Byte strobes: word 0x200=0x11223344, then write wstrb 4'b0010 wdata 0x0000AA00 -> read returns 0x1122AA44.
REQ-034 LATENCY=3, QDEPTH=2, req held high for 4 reads -> addr_ok low on the 3rd attempt until the first pop; data_ok in N+3 and N+4, in order.
REQ-035 Aliasing: write 0x0000_0010 = 0x5A5A5A5A, read 0x0000_0410 (DEPTH_LOG2=8) -> 0x5A5A5A5A.
REQ-036 Reset mid-flight: two reads outstanding with LATENCY=4, assert resetn low for 1 cycle -> no data_ok ever for them, and addr_ok=0 during reset.
REQ-037 Write with wstrb=0 to a word holding 0x12345678 -> data_ok pulses once and a later read returns 0x12345678.
